// File: rtl/hidden_err_pkg.sv
// Shared definitions for the hidden-layer error (backprop) block.
// Holds the fixed-point format, the FSM state encoding and the
// saturation helper used by both the top level and the multiplier.
package hidden_err_pkg;

  // Default signed fixed-point format: 32-bit words, 24 fractional bits.
  localparam int     WIDTH_DEF = 32;
  localparam int     FRAC      = 24;
  localparam longint ONE       = longint'(1) << FRAC;

  // Accumulator carries 8 guard bits above the word width so a sum of
  // several full-scale products does not wrap before saturation.
  localparam int     ACC_W     = WIDTH_DEF + 8;

  // FSM encoding, kept as plain constants for compatibility with older
  // tools that consume this package.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DERIV = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Clamp a wide signed value into the range of a signed 'width'-bit word.
  // Callers sign-extend into the 128-bit argument and truncate the result.
  function automatic logic signed [127:0] sat(input logic signed [127:0] value,
                                              input int width);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (width - 1));
    if (value > hi)      sat = hi;
    else if (value < lo) sat = lo;
    else                 sat = value;
  endfunction

endpackage

// File: rtl/hidden_err_if.sv
// Handshake and data bus of the hidden-layer error block.
// master: drives start and the operand buses, observes o_d/busy/done.
// slave : the hidden_err block itself.
interface hidden_err_if
  import hidden_err_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int N_HL_P = 3,
  parameter int WIDTH  = WIDTH_DEF
) ();

  logic                            start;  // request one computation
  logic [N_OUT*WIDTH-1:0]          i_d;    // output-layer deltas, element k at k*WIDTH
  logic [N_OUT*N_HL_P*WIDTH-1:0]   i_w;    // w[k][j] at element k*N_HL_P+j
  logic [N_HL_P*WIDTH-1:0]         i_a;    // stored hidden activations
  logic [N_HL_P*WIDTH-1:0]         o_d;    // hidden deltas, registered
  logic                            busy;   // high outside IDLE
  logic                            done;   // one-cycle completion pulse

  modport master (
    output start, i_d, i_w, i_a,
    input  o_d, busy, done
  );

  modport slave (
    input  start, i_d, i_w, i_a,
    output o_d, busy, done
  );

endinterface

// File: rtl/hidden_err_fxp_mul_sat.sv
// Purpose  : signed AW x BW fixed-point multiply, >>> FRAC_BITS, saturate to OW.
// Latency  : combinational, zero cycles.
// Backpres.: none; pure datapath.
// Ports    : a (AW signed), b (BW signed) in; y (OW signed) out.
module fxp_mul_sat
  import hidden_err_pkg::*;
#(
  parameter int AW        = WIDTH_DEF + 1,
  parameter int BW        = WIDTH_DEF,
  parameter int OW        = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [OW-1:0] y
);

  logic signed [AW+BW-1:0] prod;
  logic signed [AW+BW-1:0] shf;
  logic signed [127:0]     ext;

  assign prod = a * b;
  // Arithmetic shift: truncates toward minus infinity.
  assign shf  = prod >>> FRAC_BITS;
  assign ext  = {{(128-AW-BW){shf[AW+BW-1]}}, shf};
  assign y    = OW'(sat(ext, OW));

endmodule

// File: rtl/hidden_err.sv
// Purpose  : hidden-layer error delta_h[j] = (sum_k w[k][j]*d[k]) * a_j*(1-a_j), one shared MAC.
// Latency  : done N_HL_P*(N_OUT+2) edges after the start-sampling edge (12 with defaults).
// Backpres.: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports    : clk, rst (async active-low), bus (hidden_err_if.slave: start/i_d/i_w/i_a in,
//            o_d/busy/done out).
module hidden_err
  import hidden_err_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int N_HL_P = 3,
  parameter int WIDTH  = WIDTH_DEF
) (
  input logic        clk,
  input logic        rst,
  hidden_err_if.slave bus
);

  localparam int ACC_BITS = WIDTH + (ACC_W - WIDTH_DEF);
  localparam int KW       = (N_OUT  > 1) ? $clog2(N_OUT)  : 1;
  localparam int JW       = (N_HL_P > 1) ? $clog2(N_HL_P) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_HL_P - 1);
  localparam logic signed [WIDTH:0] ONE_X = (WIDTH+1)'(ONE);

  logic [2:0]                 state;
  logic [KW-1:0]              k;
  logic [JW-1:0]              j;
  logic signed [ACC_BITS-1:0] acc;
  logic signed [WIDTH-1:0]    der;

  // Snapshot of the operands, taken on the start edge so the caller may
  // change its buses while the run is in flight.
  logic signed [WIDTH-1:0]    sd [N_OUT];
  logic signed [WIDTH-1:0]    sw [N_OUT][N_HL_P];
  logic signed [WIDTH-1:0]    sa [N_HL_P];
  logic signed [WIDTH-1:0]    od [N_HL_P];

  // MAC term keeps the full shifted product (no saturation); the guard
  // bits of the accumulator absorb the sum.
  logic signed [2*WIDTH-1:0]  mprod;
  logic signed [2*WIDTH-1:0]  mshf;
  logic signed [ACC_BITS-1:0] mterm;

  assign mprod = sw[k][j] * sd[k];
  assign mshf  = mprod >>> FRAC;
  assign mterm = ACC_BITS'(mshf);

  // Shared saturating multiplier: derivative in DERIV, final scale in SCALE.
  logic signed [WIDTH:0]   a_x;
  logic signed [WIDTH:0]   one_minus_a;
  logic signed [WIDTH-1:0] acc_sat;
  logic signed [WIDTH:0]   mul_a;
  logic signed [WIDTH-1:0] mul_b;
  logic signed [WIDTH-1:0] mul_y;

  // ONE - a needs one extra bit: for a near -2^(WIDTH-1-FRAC) it exceeds
  // the word range.
  assign a_x         = {sa[j][WIDTH-1], sa[j]};
  assign one_minus_a = ONE_X - a_x;
  assign acc_sat     = WIDTH'(sat({{(128-ACC_BITS){acc[ACC_BITS-1]}}, acc}, WIDTH));

  always_comb begin
    mul_a = one_minus_a;
    mul_b = sa[j];
    if (state == S_SCALE) begin
      mul_a = {acc_sat[WIDTH-1], acc_sat};
      mul_b = der;
    end
  end

  fxp_mul_sat #(
    .AW        (WIDTH + 1),
    .BW        (WIDTH),
    .OW        (WIDTH),
    .FRAC_BITS (FRAC)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .y (mul_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
      j     <= '0;
      acc   <= '0;
      der   <= '0;
      for (int kk = 0; kk < N_OUT; kk++) begin
        sd[kk] <= '0;
        for (int jj = 0; jj < N_HL_P; jj++) sw[kk][jj] <= '0;
      end
      for (int jj = 0; jj < N_HL_P; jj++) begin
        sa[jj] <= '0;
        od[jj] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            for (int kk = 0; kk < N_OUT; kk++) begin
              sd[kk] <= bus.i_d[kk*WIDTH +: WIDTH];
              for (int jj = 0; jj < N_HL_P; jj++)
                sw[kk][jj] <= bus.i_w[(kk*N_HL_P+jj)*WIDTH +: WIDTH];
            end
            for (int jj = 0; jj < N_HL_P; jj++) sa[jj] <= bus.i_a[jj*WIDTH +: WIDTH];
            k     <= '0;
            j     <= '0;
            acc   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + mterm;
          if (k == K_LAST) state <= S_DERIV;
          else             k     <= k + 1'b1;
        end
        S_DERIV: begin
          der   <= mul_y;
          state <= S_SCALE;
        end
        S_SCALE: begin
          od[j] <= mul_y;
          acc   <= '0;
          k     <= '0;
          if (j == J_LAST) begin
            state <= S_DONE;
          end else begin
            j     <= j + 1'b1;
            state <= S_MAC;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_HL_P; g++) begin : g_out
    assign bus.o_d[g*WIDTH +: WIDTH] = od[g];
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);

endmodule

// File: doc/hidden_err.md
Name: hidden_err

Overview:
- Backward-direction companion to the forward DNN array.
- Computes the hidden-layer error terms delta_h[j] = (sum_k w[k][j]*delta_o[k]) * a_j*(1-a_j) for sigmoid hidden perceptrons.
- Inputs are the output-layer deltas, the output-layer weights, and the hidden activations held in the hidden storage register.
- Serial: one shared MAC, driven by a start/busy/done handshake. Its result feeds the hidden-layer weight update.

Parameters:
- N_OUT, 2, number of output perceptrons (deltas in).
- N_HL_P, 3, number of hidden perceptrons (deltas out).
- WIDTH, 32, signed fixed-point word width.
- FRAC, 24, fractional bits. ONE = 1<<FRAC.
- ACC_W, WIDTH+8, internal accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin one computation. Sampled only in IDLE.
- i_d  in  N_OUT*WIDTH  output deltas; element k = bits [k*WIDTH +: WIDTH].
- i_w  in  N_OUT*N_HL_P*WIDTH  output-layer weights; w[k][j] at index k*N_HL_P+j.
- i_a  in  N_HL_P*WIDTH  stored hidden activations a_j.
- o_d  out  N_HL_P*WIDTH  hidden deltas, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; o_d complete and valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; o_d, accumulator, counters, snapshot all 0; busy=0; done=0.
- Reset mid-run aborts immediately. No partial result is preserved.
- States: IDLE, MAC, DERIV, SCALE, DONE.
- IDLE, start=1 at an edge:
  - snapshot i_d, i_w and i_a into internal registers.
  - j=0, k=0, acc=0; go to MAC.
  - Inputs may change after this edge without affecting the run.
- MAC, one cycle per k:
  - acc += (w[k][j]*d[k]) >>> FRAC, using a 2*WIDTH product, sign-extended to ACC_W.
  - On k=N_OUT-1 go to DERIV; otherwise k++.
- DERIV: der = (a_j*(ONE-a_j)) >>> FRAC, registered; ONE-a_j is computed at WIDTH+1 bits.
- SCALE:
  - o_d[j] = sat((sat(acc)*der) >>> FRAC).
  - acc=0, k=0.
  - If j=N_HL_P-1 go to DONE; otherwise j++ and go to MAC.
- DONE: done=1 for exactly this cycle, then IDLE.
- Arithmetic rules:
  - All shifts are arithmetic (truncate toward -inf).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency: done is high in the cycle following edge E0+N_HL_P*(N_OUT+2), where E0 is the start-sampling edge. With defaults that is 12 edges after E0.
- Repetition period with start held high: N_HL_P*(N_OUT+2)+2 cycles (14 with defaults).
- o_d elements update progressively at each SCALE edge. Consumers sample on done. o_d holds its value between runs.
- start while busy (including DONE) is ignored; it is not queued.

Decomposition:
- Shared package hidden_err_pkg:
  - state encoding enum.
  - FRAC, ONE, ACC_W.
  - saturation function sat(value, WIDTH).
- One sub-module: fxp_mul_sat.
  - Signed WIDTH x WIDTH multiply, >>> FRAC, saturate to WIDTH.
  - Used in DERIV and SCALE.
  - MAC keeps the unsaturated shifted product.

Test Plan:
- Nominal:
  - Stimulus: rst released, i_d=[0x01000000,0], all w=0x00800000 (0.5), all a=0x00800000, start pulse.
  - Response: done exactly 12 cycles after the start edge; every o_d element = 0x00200000 (0.125); busy high over those 12 cycles.
- Saturation:
  - Stimulus: all w=0x7FFFFFFF, all d=0x7FFFFFFF, all a=0xFF000000 (-1.0, der=-2.0).
  - Response: every o_d element = 0x80000000.
- Zero derivative:
  - Stimulus: a=[0, 0x01000000, 0] with arbitrary nonzero w and d.
  - Response: o_d all 0; done timing unchanged.
- Handshake:
  - Stimulus: second start pulse at cycles 3 and 12 (DONE) of a run; inputs changed right after E0.
  - Response: only one done pulse, one cycle wide; o_d matches the snapshot inputs; no extra run starts.
- Reset mid-run:
  - Stimulus: rst=0 asynchronously at cycle 5 (between edges).
  - Response: busy=0 and o_d=0 with no clock edge. After release plus start, the nominal result is obtained in 12 cycles.
- Back-to-back:
  - Stimulus: start held high for 40 cycles with nominal data.
  - Response: done pulses at E0+12, E0+26 and E0+40; o_d=0x00200000 throughout after the first done.
